// File: rtl/mem_stage.sv
// Memory-access stage: little-endian doubleword loads/stores on a wrapping byte
// array, branch decision for the PC mux, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int DEPTH_BYTES = 64,
  parameter int ADDR_BITS   = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EXM_RegWrite,
  input  logic        EXM_MemRead,
  input  logic        EXM_MemWrite,
  input  logic        EXM_MemToReg,
  input  logic        EXM_Branch,
  input  logic        EXM_Zero,
  input  logic [63:0] EXM_Adder_out,
  input  logic [63:0] EXM_ALUResult,
  input  logic [63:0] EXM_ReadData2,
  input  logic [4:0]  EXM_rd,
  output logic        PCSrc,
  output logic [63:0] BranchTarget,
  output logic        MW_RegWrite,
  output logic        MW_MemToReg,
  output logic [63:0] MW_ReadData,
  output logic [63:0] MW_ALUResult,
  output logic [4:0]  MW_rd
);

  logic [7:0]           mem_q [DEPTH_BYTES];
  logic [7:0]           mem_d [DEPTH_BYTES];
  logic [ADDR_BITS-1:0] addr;
  logic [63:0]          rd_data;

  logic        reg_write_q, mem_to_reg_q;
  logic [63:0] read_data_q, read_data_d, alu_result_q;
  logic [4:0]  rd_q;

  assign addr         = EXM_ALUResult[ADDR_BITS-1:0];
  assign PCSrc        = EXM_Branch & EXM_Zero;
  assign BranchTarget = EXM_Adder_out;

  // Byte lanes index with ADDR_BITS-wide sums so accesses wrap at the array end.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_lane
      assign rd_data[8*gi +: 8] = mem_q[addr + ADDR_BITS'(gi)];
    end
  endgenerate

  always_comb begin
    mem_d = mem_q;
    if (EXM_MemWrite) begin
      for (int i = 0; i < 8; i++) begin
        mem_d[addr + ADDR_BITS'(i)] = EXM_ReadData2[8*i +: 8];
      end
    end
  end

  // Read comes from mem_q, so a simultaneous store is seen only on later loads.
  assign read_data_d = EXM_MemRead ? rd_data : 64'd0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      mem_q        <= '{default: 8'h00};
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= 64'd0;
      alu_result_q <= 64'd0;
      rd_q         <= 5'd0;
    end else begin
      mem_q        <= mem_d;
      reg_write_q  <= EXM_RegWrite;
      mem_to_reg_q <= EXM_MemToReg;
      read_data_q  <= read_data_d;
      alu_result_q <= EXM_ALUResult;
      rd_q         <= EXM_rd;
    end
  end

  assign MW_RegWrite  = reg_write_q;
  assign MW_MemToReg  = mem_to_reg_q;
  assign MW_ReadData  = read_data_q;
  assign MW_ALUResult = alu_result_q;
  assign MW_rd        = rd_q;

endmodule
